tick_gen: RTL and testbench

Parametrised tick generator replacing the fixed 50 MHz → 1 kHz divider in the reaction-timer datapath. It derives a base-rate single-cycle enable strobe from the system clock, then cascades decade stages so the base tick and slower ticks (10 ms, 100 ms, 1 s at defaults) come from one counter chain. It also keeps a 50 % duty square output at half the base rate for legacy/LED use. Downstream timers, the LFSR delay and the display blink logic run on `clk` and qualify on `tick[k]`; no derived clocks.

---
 rtl/tick_gen.sv | 88 ++++++++
 tb/tb_tick_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Tick generator: a prescaler produces a base-rate enable strobe.
// Cascaded decade stages then produce slower strobes, and a square wave toggles at the base rate.
module tick_gen #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BASE_HZ    = 1000,
    parameter int unsigned NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  sync_clr,
    output logic [NUM_STAGES-1:0] tick,
    output logic                  sq
);

    localparam int unsigned DIV   = (BASE_HZ == 0) ? 0 : CLK_HZ / BASE_HZ;
    localparam int unsigned PRE_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    generate
        if (BASE_HZ == 0 || (CLK_HZ % BASE_HZ) != 0 || DIV < 2 || NUM_STAGES < 1) begin : g_bad_params
            $error("tick_gen: CLK_HZ must be a multiple of BASE_HZ, DIV >= 2, NUM_STAGES >= 1");
        end
    endgenerate

    logic [PRE_W-1:0]      r_pre_cnt;
    logic [NUM_STAGES-1:0] r_tick;
    logic                  r_sq;
    logic [NUM_STAGES-1:0] w_at_max;
    logic [NUM_STAGES-1:0] w_wrap;

    assign w_at_max[0] = (r_pre_cnt == PRE_MAX);

    // Wrap events ripple down the chain within one cycle, so a slow tick
    // always coincides with every faster tick.
    always_comb begin
        w_wrap    = '0;
        w_wrap[0] = en && w_at_max[0];
        for (int k = 1; k < NUM_STAGES; k++) begin
            w_wrap[k] = w_wrap[k-1] && w_at_max[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
            r_tick    <= '0;
            r_sq      <= 1'b0;
        end else if (sync_clr) begin
            r_pre_cnt <= '0;
            r_tick    <= '0;
            r_sq      <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (en) begin
                r_pre_cnt <= w_wrap[0] ? '0 : r_pre_cnt + PRE_W'(1);
            end
            if (w_wrap[0]) begin
                r_sq <= ~r_sq;
            end
        end
    end

    genvar k;
    generate
        for (k = 1; k < NUM_STAGES; k++) begin : g_dec
            logic [3:0] r_dec;

            assign w_at_max[k] = (r_dec == 4'd9);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_dec <= 4'd0;
                end else if (sync_clr) begin
                    r_dec <= 4'd0;
                end else if (w_wrap[k-1]) begin
                    r_dec <= w_at_max[k] ? 4'd0 : r_dec + 4'd1;
                end
            end
        end
    endgenerate

    assign tick = r_tick;
    assign sq   = r_sq;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen at DIV=10, 3 stages: per-edge scoreboard against an
// enabled-edge-count model plus table checkpoints for the timing corner cases.
module tb_tick_gen;

    localparam int unsigned CLK_HZ     = 1000;
    localparam int unsigned BASE_HZ    = 100;
    localparam int unsigned NUM_STAGES = 3;
    localparam int unsigned DIV        = CLK_HZ / BASE_HZ;

    logic                  clk;
    logic                  reset_n;
    logic                  en;
    logic                  sync_clr;
    logic [NUM_STAGES-1:0] tick;
    logic                  sq;

    tick_gen #(
        .CLK_HZ    (CLK_HZ),
        .BASE_HZ   (BASE_HZ),
        .NUM_STAGES(NUM_STAGES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .sync_clr(sync_clr),
        .tick    (tick),
        .sq      (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                    edge_no;
        logic                  en;
        logic                  clr;
        logic                  chk;
        logic [NUM_STAGES-1:0] exp_tick;
        logic                  exp_sq;
    } vec_t;

    typedef struct {
        logic [NUM_STAGES-1:0] tick;
        logic                  sq;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: enabled edges since the last reset/clear, and square level.
    int   m_n;
    logic m_sq;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_n  = 0;
        m_sq = 1'b0;
        sb_q.delete();
    endtask

    // Drive one edge's inputs, predict outputs, then compare after the edge.
    task automatic step(input logic en_v, input logic clr_v);
        exp_t e;
        int   period;
        @(negedge clk);
        en       = en_v;
        sync_clr = clr_v;
        e.tick   = '0;
        if (clr_v) begin
            m_n  = 0;
            m_sq = 1'b0;
        end else if (en_v) begin
            m_n++;
            period = DIV;
            for (int k = 0; k < NUM_STAGES; k++) begin
                e.tick[k] = (m_n % period) == 0;
                period    = period * 10;
            end
            if (e.tick[0]) m_sq = ~m_sq;
        end
        e.sq = m_sq;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_tick", 32'(tick), 32'(e.tick));
            check("sb_sq", 32'(sq), 32'(e.sq));
        end
    endtask

    task automatic add(input int edge_no, input logic en_v, input logic clr_v,
                       input logic chk, input logic [NUM_STAGES-1:0] t, input logic s);
        vec_t v;
        v.edge_no  = edge_no;
        v.en       = en_v;
        v.clr      = clr_v;
        v.chk      = chk;
        v.exp_tick = t;
        v.exp_sq   = s;
        tbl.push_back(v);
    endtask

    // Run edges 1..n; default inputs en=1, clr=0 unless a table row overrides.
    task automatic run_table(input string tag, input int n);
        for (int e = 1; e <= n; e++) begin
            logic en_v, clr_v, chk;
            int   idx;
            en_v = 1'b1; clr_v = 1'b0; chk = 1'b0; idx = -1;
            for (int i = 0; i < tbl.size(); i++) begin
                if (tbl[i].edge_no == e) begin
                    idx   = i;
                    en_v  = tbl[i].en;
                    clr_v = tbl[i].clr;
                    chk   = tbl[i].chk;
                end
            end
            step(en_v, clr_v);
            if (chk) begin
                check($sformatf("%s_tick_e%0d", tag, e), 32'(tick), 32'(tbl[idx].exp_tick));
                check($sformatf("%s_sq_e%0d", tag, e), 32'(sq), 32'(tbl[idx].exp_sq));
            end
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        en       = 1'b0;
        sync_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_sq", 32'(sq), 32'd0);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        sync_clr = 1'b0;
        model_reset();
        #1;
        check("por_tick", 32'(tick), 32'd0);
        check("por_sq", 32'(sq), 32'd0);
        do_reset();

        // Free-running: tick[0] every 10, tick[1] every 100, tick[2] at 1000.
        add(9,    1, 0, 1, 3'b000, 0);
        add(10,   1, 0, 1, 3'b001, 1);
        add(11,   1, 0, 1, 3'b000, 1);
        add(19,   1, 0, 1, 3'b000, 1);
        add(20,   1, 0, 1, 3'b001, 0);
        add(30,   1, 0, 1, 3'b001, 1);
        add(100,  1, 0, 1, 3'b011, 0);
        add(101,  1, 0, 1, 3'b000, 0);
        add(200,  1, 0, 1, 3'b011, 0);
        add(999,  1, 0, 1, 3'b000, 1);
        add(1000, 1, 0, 1, 3'b111, 0);
        add(1001, 1, 0, 1, 3'b000, 0);
        run_table("free", 1001);

        // Stall on edges 5..8 shifts the first tick to 14.
        do_reset();
        for (int e = 5; e <= 8; e++) add(e, 0, 0, 0, 3'b000, 0);
        add(13, 1, 0, 1, 3'b000, 0);
        add(14, 1, 0, 1, 3'b001, 1);
        add(15, 1, 0, 1, 3'b000, 1);
        add(24, 1, 0, 1, 3'b001, 0);
        run_table("stall", 25);

        // en drops exactly on the wrap edge: tick deferred to edge 13.
        do_reset();
        add(10, 0, 0, 1, 3'b000, 0);
        add(11, 0, 0, 0, 3'b000, 0);
        add(12, 0, 0, 1, 3'b000, 0);
        add(13, 1, 0, 1, 3'b001, 1);
        add(22, 1, 0, 1, 3'b000, 1);
        add(23, 1, 0, 1, 3'b001, 0);
        run_table("wrapstall", 24);

        // sync_clr coincident with the tick[0]/tick[1] wrap: clear wins.
        do_reset();
        add(99,  1, 0, 1, 3'b000, 1);
        add(100, 1, 1, 1, 3'b000, 0);
        add(109, 1, 0, 1, 3'b000, 0);
        add(110, 1, 0, 1, 3'b001, 1);
        add(199, 1, 0, 1, 3'b000, 1);
        add(200, 1, 0, 1, 3'b011, 0);
        run_table("clr", 200);

        // Asynchronous reset mid-cycle at count 57, sq high beforehand.
        do_reset();
        add(57, 1, 0, 1, 3'b000, 1);
        run_table("pre_arst", 57);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_now_tick", 32'(tick), 32'd0);
        check("arst_now_sq", 32'(sq), 32'd0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        add(9,   1, 0, 1, 3'b000, 0);
        add(10,  1, 0, 1, 3'b001, 1);
        add(90,  1, 0, 1, 3'b001, 1);
        add(100, 1, 0, 1, 3'b011, 0);
        run_table("post_arst", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
